sched_sequencer: RTL
====================

# sched_sequencer

Programmable schedule sequencer for the shared ALU/MUL/LOG datapath. It replaces a hard-coded per-kernel cycle FSM with a control-word memory that is loaded over a simple write port while idle. On `start`, it steps through the stored words one per cycle, driving unit selects, opcodes and register enables. It finishes with the same `op_ready` / `done_next` / `result_en` handshake used by the fixed controllers.

## Interface
- `DEPTH`, 16 — number of control-word slots; a power of 2, at least 2.
- `SEL_W`, 4 — width of each operand select.
- `EN_W`, 8 — number of datapath register enables.
- Derived: `AW = $clog2(DEPTH)`; `CW_W = 6*SEL_W + EN_W + 6`.
- Control word layout, MSB to LSB: `last`, `result_en`, `reg_en[EN_W-1:0]`, `log_op[1:0]`, `log_sel2`, `log_sel1`, `mul_op`, `mul_sel2`, `mul_sel1`, `alu_op`, `alu_sel2`, `alu_sel1`.

Ports:
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — run request; sampled only in IDLE.
- `hold` in 1 — stall the current step; sampled only in RUN.
- `prog_we` in 1 — control-word write strobe; honoured only in IDLE.
- `prog_addr` in AW — write address.
- `prog_data` in CW_W — control word to write.
- `op_ready` out 1 — high in IDLE.
- `done_next` out 1 — high for the single DONE cycle.
- `result_en` out 1 — from the current word, gated by hold.
- `busy` out 1 — high in RUN or DONE.
- `err` out 1 — sticky: the run ended without a `last` bit.
- `alu1_sel1`, `alu1_sel2` out SEL_W each; `alu1_op` out 1.
- `mul1_sel1`, `mul1_sel2` out SEL_W each; `mul1_op` out 1.
- `log1_sel1`, `log1_sel2` out SEL_W each; `log1_op` out 2.
- `reg_en` out EN_W — datapath register enables, gated by hold.

## Operation
- **State.** Three states: IDLE, RUN, DONE. Step counter `pc` is AW bits wide.
- **Memory.**
  - `DEPTH x CW_W` register array, written synchronously, read asynchronously at `pc`.
  - Contents are not affected by `rst` and are undefined after power-up.
- **Reset.** `rst` forces state = IDLE, `pc` = 0, `err` = 0. The next cycle all outputs are 0 except `op_ready` = 1.
- **IDLE.**
  - `op_ready` = 1; every select, op and enable output is 0.
  - `prog_we` = 1 writes `prog_data` to `mem[prog_addr]`.
  - `start` = 1 moves to RUN with `pc` = 0 and clears `err`.
  - If `prog_we` and `start` arrive in the same cycle, the write and the start both take effect. The write is visible to step 0.
- **RUN.**
  - Select and op outputs decode combinationally from `mem[pc]`.
  - `reg_en` and `result_en` equal the word's fields ANDed with `~hold`.
  - `hold` = 1: `pc` and state are frozen and selects stay driven.
  - `hold` = 0 and `last` = 1: go to DONE.
  - `hold` = 0, `last` = 0 and `pc` = DEPTH-1: go to DONE and set `err` = 1.
  - Otherwise `pc` increments by 1.
- **DONE.**
  - `done_next` = 1 and `busy` = 1; all select, op and enable outputs are 0.
  - The next state is IDLE unconditionally, and `pc` is cleared.
- **Ignored inputs.**
  - `start` outside IDLE is ignored; it is not queued.
  - `prog_we` outside IDLE is ignored and memory is unchanged.
  - `hold` outside RUN has no effect.
- **Error flag.** `err` holds its value through DONE and IDLE. Only `rst` or an accepted `start` clears it.

## Timing
- **Run latency.** `start` sampled at edge t, N-word program, no holds:
  - RUN word k is presented in cycle t+1+k, for k = 0..N-1.
  - DONE is in cycle t+N+1.
  - `op_ready` returns in cycle t+N+2.
- **Hold.** Each cycle with `hold` = 1 in RUN adds exactly one cycle to the run.
- **Single-word program.** `last` set in word 0: one RUN cycle, then DONE. Total latency from start to DONE is 2 cycles.
- **Maximum run.** DEPTH RUN cycles, then DONE with `err` = 1.
- **Write timing.** A write at edge t is readable in any RUN cycle from t+1 onward.
- **Output timing.** Outputs are combinational from state, `pc`, memory and `hold`; there is no added output register stage.

## Test plan
1. **Basic run.** Program 6 words with `last` only in word 5. Word 0 = `mul1_sel1`=0, `mul1_sel2`=1, `reg_en`=8'h01. Word 5 = `alu1_sel1`=8, `alu1_sel2`=11, `reg_en`=8'h40, `result_en`=1. Pulse `start` -> RUN cycles 1-6 present each word exactly, `done_next` = 1 in cycle 7 only, `op_ready` = 1 in cycle 8.
2. **Hold mid-run.** Repeat test 1 with `hold` = 1 for 2 cycles while word 2 is presented -> word 2's selects are driven for 3 cycles, `reg_en` = 0 for the first 2 of them, `done_next` moves to cycle 9.
3. **Missing last bit.** Program 16 words with no `last` bit -> 16 RUN cycles, DONE with `err` = 1, `err` still 1 in IDLE. The next accepted `start` clears `err`.
4. **Ignored inputs while running.** During RUN, pulse `start` and `prog_we` with address 0 and data all ones -> no restart; a rerun presents the original word 0.
5. **Reset mid-run.** Assert `rst` while word 2 is presented -> the next cycle is IDLE, `op_ready` = 1, all other outputs 0, `err` = 0. A rerun of the preserved program completes normally.
6. **Same-cycle write and start.** In IDLE, assert `prog_we` to address 0 with `alu1_sel1` = 3 in the same cycle as `start` -> the first RUN cycle shows `alu1_sel1` = 3.

Source files
------------

// File: rtl/sched_sequencer.sv
// Programmable schedule sequencer: steps through a loadable control-word memory,
// driving ALU/MUL/LOG selects and register enables, then signals completion.
module sched_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned EN_W  = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW_W = 6 * SEL_W + EN_W + 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [CW_W-1:0]   prog_data,
  output logic              op_ready,
  output logic              done_next,
  output logic              result_en,
  output logic              busy,
  output logic              err,
  output logic [SEL_W-1:0]  alu1_sel1,
  output logic [SEL_W-1:0]  alu1_sel2,
  output logic              alu1_op,
  output logic [SEL_W-1:0]  mul1_sel1,
  output logic [SEL_W-1:0]  mul1_sel2,
  output logic              mul1_op,
  output logic [SEL_W-1:0]  log1_sel1,
  output logic [SEL_W-1:0]  log1_sel2,
  output logic [1:0]        log1_op,
  output logic [EN_W-1:0]   reg_en
);

  localparam int unsigned AluS1 = 0;
  localparam int unsigned AluS2 = SEL_W;
  localparam int unsigned AluOp = 2 * SEL_W;
  localparam int unsigned MulS1 = 2 * SEL_W + 1;
  localparam int unsigned MulS2 = 3 * SEL_W + 1;
  localparam int unsigned MulOp = 4 * SEL_W + 1;
  localparam int unsigned LogS1 = 4 * SEL_W + 2;
  localparam int unsigned LogS2 = 5 * SEL_W + 2;
  localparam int unsigned LogOp = 6 * SEL_W + 2;
  localparam int unsigned RegEn = 6 * SEL_W + 4;
  localparam int unsigned ResEn = 6 * SEL_W + 4 + EN_W;
  localparam int unsigned Last  = CW_W - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            err_q, err_d;
  logic [CW_W-1:0] mem [DEPTH];
  logic [CW_W-1:0] word;
  logic            in_idle, in_run, in_done;

  assign in_idle = (state_q == StIdle);
  assign in_run  = (state_q == StRun);
  assign in_done = (state_q == StDone);
  assign word    = mem[pc_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
          err_d   = 1'b0;
        end
      end
      StRun: begin
        if (!hold) begin
          if (word[Last]) begin
            state_d = StDone;
          end else if (pc_q == AW'(DEPTH - 1)) begin
            // Ran off the end of the memory without a terminating word.
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        pc_d    = '0;
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Memory is deliberately left out of reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (!rst && in_idle && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    op_ready  = in_idle;
    done_next = in_done;
    busy      = in_run || in_done;
    err       = err_q;
    alu1_sel1 = in_run ? word[AluS1 +: SEL_W] : '0;
    alu1_sel2 = in_run ? word[AluS2 +: SEL_W] : '0;
    alu1_op   = in_run ? word[AluOp] : 1'b0;
    mul1_sel1 = in_run ? word[MulS1 +: SEL_W] : '0;
    mul1_sel2 = in_run ? word[MulS2 +: SEL_W] : '0;
    mul1_op   = in_run ? word[MulOp] : 1'b0;
    log1_sel1 = in_run ? word[LogS1 +: SEL_W] : '0;
    log1_sel2 = in_run ? word[LogS2 +: SEL_W] : '0;
    log1_op   = in_run ? word[LogOp +: 2] : 2'b00;
    reg_en    = (in_run && !hold) ? word[RegEn +: EN_W] : '0;
    result_en = in_run && !hold && word[ResEn];
  end

endmodule
